// File: rtl/led_event_scheduler.sv
// ============================================================================
//  Module   : led_event_scheduler
//  Purpose  : Latches four LED event requests and blinks the colour of the
//             highest-priority pending one for a fixed number of periods.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_event_scheduler #(
    parameter int HALF_PERIOD = 250000,
    parameter int BLINKS      = 3
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       startgame,
    input  logic [3:0] req,
    output logic       green,
    output logic       red,
    output logic       blue,
    output logic [3:0] grant,
    output logic       busy
);

    localparam int c_TIMER_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int c_BLINK_W = (BLINKS > 1) ? $clog2(BLINKS) : 1;

    localparam logic [c_TIMER_W-1:0] c_TIMER_RELOAD = c_TIMER_W'(HALF_PERIOD - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST   = c_BLINK_W'(BLINKS - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_ON   = 2'd1;
    localparam logic [1:0] c_S_OFF  = 2'd2;

    logic [1:0]           r_state,     w_state_nxt;
    logic [c_TIMER_W-1:0] r_timer,     w_timer_nxt;
    logic [c_BLINK_W-1:0] r_blink_cnt, w_blink_nxt;
    logic [3:0]           r_pending,   w_pending_nxt;
    logic [3:0]           r_grant,     w_grant_nxt;
    logic [2:0]           r_led,       w_led_nxt;   // {red, green, blue}
    logic                 r_busy,      w_busy_nxt;
    logic [3:0]           w_arb;
    logic [3:0]           w_clr;

    function automatic logic [2:0] f_colour(input logic [3:0] g);
        logic [2:0] rgb;
        rgb = 3'b000;
        if (g[0]) rgb = 3'b100;
        if (g[1]) rgb = 3'b010;
        if (g[2]) rgb = 3'b001;
        if (g[3]) rgb = 3'b111;
        return rgb;
    endfunction

    // Fixed priority: bit 3 wins
    always_comb begin
        w_arb = 4'b0000;
        if      (r_pending[3]) w_arb = 4'b1000;
        else if (r_pending[2]) w_arb = 4'b0100;
        else if (r_pending[1]) w_arb = 4'b0010;
        else if (r_pending[0]) w_arb = 4'b0001;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_blink_nxt = r_blink_cnt;
        w_grant_nxt = r_grant;
        w_led_nxt   = r_led;
        w_busy_nxt  = r_busy;
        w_clr       = 4'b0000;

        case (r_state)
            c_S_IDLE: begin
                w_led_nxt   = 3'b000;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                if (r_pending != 4'b0000) begin
                    w_grant_nxt = w_arb;
                    w_timer_nxt = c_TIMER_RELOAD;
                    w_blink_nxt = '0;
                    w_led_nxt   = f_colour(w_arb);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = c_S_ON;
                end
            end
            c_S_ON: begin
                if (r_timer == '0) begin
                    w_timer_nxt = c_TIMER_RELOAD;
                    w_led_nxt   = 3'b000;
                    w_state_nxt = c_S_OFF;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            c_S_OFF: begin
                w_led_nxt = 3'b000;
                if (r_timer == '0) begin
                    if (r_blink_cnt == c_BLINK_LAST) begin
                        w_clr       = r_grant;
                        w_grant_nxt = 4'b0000;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_blink_nxt = r_blink_cnt + 1'b1;
                        w_timer_nxt = c_TIMER_RELOAD;
                        w_led_nxt   = f_colour(r_grant);
                        w_state_nxt = c_S_ON;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_grant_nxt = 4'b0000;
                w_led_nxt   = 3'b000;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // A request landing in the clearing cycle re-arms its own bit
        w_pending_nxt = (r_pending & ~w_clr) | req;

        if (!startgame) begin
            w_state_nxt   = c_S_IDLE;
            w_pending_nxt = 4'b0000;
            w_led_nxt     = 3'b000;
            w_grant_nxt   = 4'b0000;
            w_busy_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state     <= c_S_IDLE;
            r_timer     <= '0;
            r_blink_cnt <= '0;
            r_pending   <= 4'b0000;
            r_grant     <= 4'b0000;
            r_led       <= 3'b000;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_pending   <= w_pending_nxt;
            r_grant     <= w_grant_nxt;
            r_led       <= w_led_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign red   = r_led[2];
    assign green = r_led[1];
    assign blue  = r_led[0];
    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_event_scheduler.sv
// ============================================================================
//  Module   : tb_led_event_scheduler
//  Purpose  : Self-checking bench for led_event_scheduler against a
//             service-schedule reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_event_scheduler;

    localparam int HP  = 4;
    localparam int NB  = 2;
    localparam int SVC = 2 * HP * NB;

    logic       clk = 1'b0;
    logic       resetb;
    logic       startgame;
    logic [3:0] req;
    logic       green, red, blue, busy;
    logic [3:0] grant;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending set, index of event being shown, cycles into its service
    logic [3:0] m_pend;
    int         m_grant;
    int         m_k;

    always #5 clk = ~clk;

    led_event_scheduler #(.HALF_PERIOD(HP), .BLINKS(NB)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .startgame (startgame),
        .req       (req),
        .green     (green),
        .red       (red),
        .blue      (blue),
        .grant     (grant),
        .busy      (busy)
    );

    function automatic logic [2:0] colour(input int g);
        case (g)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            3:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] exp_out();
        logic [2:0] rgb;
        logic [3:0] g;
        if (m_grant < 0) return 8'h00;
        rgb = ((m_k / HP) % 2 == 0) ? colour(m_grant) : 3'b000;
        g   = 4'b0001 << m_grant;
        return {rgb, g, 1'b1};
    endfunction

    task automatic model_reset();
        m_pend  = 4'b0000;
        m_grant = -1;
        m_k     = 0;
    endtask

    task automatic model_edge();
        if (!resetb || !startgame) begin
            model_reset();
        end else if (m_grant < 0) begin
            for (int b = 3; b >= 0; b--)
                if (m_pend[b] && m_grant < 0) begin
                    m_grant = b;
                    m_k     = 0;
                end
            m_pend = m_pend | req;
        end else begin
            m_k++;
            if (m_k == SVC) begin
                m_pend[m_grant] = 1'b0;
                m_grant = -1;
                m_k     = 0;
            end
            m_pend = m_pend | req;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Clear everything through startgame so each scenario starts at cycle 0 idle
    task automatic restart();
        startgame = 1'b0;
        req       = 4'b0000;
        tick();
        startgame = 1'b1;
    endtask

    task automatic test_reset();
        resetb    = 1'b0;
        startgame = 1'b0;
        req       = 4'b1111;
        model_reset();
        #3;
        checks++;
        if ({red, green, blue, grant, busy} !== 8'h00)
            $display("FAIL reset_state: got %b expected %b", {red, green, blue, grant, busy}, 8'h00);
        tick();
        tick();
        resetb = 1'b1;
        req    = 4'b0000;
        tick();
        checks++;
        if ({red, green, blue, grant, busy} !== 8'h00)
            $display("FAIL reset_release: got %b expected %b", {red, green, blue, grant, busy}, 8'h00);
    endtask

    task automatic test_single();
        logic exp_g, exp_b;
        restart();
        for (int c = 0; c <= 31; c++) begin
            req = (c == 10) ? 4'b0010 : 4'b0000;
            checks++;
            if ({red, green, blue, grant, busy} !== exp_out()) begin
                failures++;
                $display("FAIL single_model c=%0d: got %b expected %b", c, {red, green, blue, grant, busy}, exp_out());
            end
            exp_g = (c >= 12 && c <= 15) || (c >= 20 && c <= 23);
            exp_b = (c >= 12 && c <= 27);
            checks++;
            if (green !== exp_g || busy !== exp_b || grant !== (exp_b ? 4'b0010 : 4'b0000)) begin
                failures++;
                $display("FAIL single_timing c=%0d: got g=%b busy=%b grant=%b expected g=%b busy=%b", c, green, busy, grant, exp_g, exp_b);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        logic exp_r, exp_bl;
        restart();
        for (int c = 0; c <= 42; c++) begin
            req = (c == 10) ? 4'b0101 : 4'b0000;
            checks++;
            if ({red, green, blue, grant, busy} !== exp_out()) begin
                failures++;
                $display("FAIL priority_model c=%0d: got %b expected %b", c, {red, green, blue, grant, busy}, exp_out());
            end
            exp_bl = (c >= 12 && c <= 15) || (c >= 20 && c <= 23);
            exp_r  = (c >= 29 && c <= 32) || (c >= 37 && c <= 40);
            checks++;
            if (red !== exp_r || blue !== exp_bl) begin
                failures++;
                $display("FAIL priority_timing c=%0d: got r=%b b=%b expected r=%b b=%b", c, red, blue, exp_r, exp_bl);
            end
            tick();
        end
    endtask

    task automatic test_no_preempt();
        restart();
        for (int c = 0; c <= 34; c++) begin
            req = (c == 10) ? 4'b0100 : (c == 14) ? 4'b1000 : 4'b0000;
            checks++;
            if ({red, green, blue, grant, busy} !== exp_out()) begin
                failures++;
                $display("FAIL no_preempt_model c=%0d: got %b expected %b", c, {red, green, blue, grant, busy}, exp_out());
            end
            if (c == 20 || c == 29) begin
                checks++;
                if ({red, green, blue, grant} !== ((c == 20) ? 7'b001_0100 : 7'b111_1000)) begin
                    failures++;
                    $display("FAIL no_preempt_point c=%0d: got %b", c, {red, green, blue, grant});
                end
            end
            tick();
        end
    endtask

    task automatic test_rearm();
        restart();
        for (int c = 0; c <= 33; c++) begin
            req = (c == 10 || c == 27) ? 4'b0010 : 4'b0000;
            checks++;
            if ({red, green, blue, grant, busy} !== exp_out()) begin
                failures++;
                $display("FAIL rearm_model c=%0d: got %b expected %b", c, {red, green, blue, grant, busy}, exp_out());
            end
            if (c == 28 || c == 29) begin
                checks++;
                if ({green, busy} !== ((c == 28) ? 2'b00 : 2'b11)) begin
                    failures++;
                    $display("FAIL rearm_point c=%0d: got green=%b busy=%b", c, green, busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_startgame_drop();
        restart();
        for (int c = 0; c <= 45; c++) begin
            req       = (c == 10) ? 4'b0010 : (c == 12) ? 4'b0001 : 4'b0000;
            startgame = (c != 18);
            checks++;
            if ({red, green, blue, grant, busy} !== exp_out()) begin
                failures++;
                $display("FAIL startgame_model c=%0d: got %b expected %b", c, {red, green, blue, grant, busy}, exp_out());
            end
            if (c >= 19) begin
                checks++;
                if ({red, green, blue, grant, busy} !== 8'h00) begin
                    failures++;
                    $display("FAIL startgame_idle c=%0d: got %b expected 0", c, {red, green, blue, grant, busy});
                end
            end
            tick();
        end
        startgame = 1'b1;
    endtask

    task automatic test_async_reset();
        restart();
        for (int c = 0; c <= 4; c++) begin
            req = (c == 0) ? 4'b0011 : 4'b0000;
            tick();
        end
        checks++;
        if ({red, green, blue, grant, busy} !== exp_out() || green !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: got %b expected %b", {red, green, blue, grant, busy}, exp_out());
        end
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({red, green, blue, grant, busy} !== 8'h00) begin
            failures++;
            $display("FAIL async_immediate: got %b expected 0", {red, green, blue, grant, busy});
        end
        tick();
        tick();
        resetb = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({red, green, blue, grant, busy} !== 8'h00 || exp_out() !== 8'h00) begin
                failures++;
                $display("FAIL async_after c=%0d: got %b expected 0", c, {red, green, blue, grant, busy});
            end
            tick();
        end
    endtask

    task automatic test_random();
        restart();
        for (int c = 0; c < 1500; c++) begin
            startgame = ($urandom_range(0, 149) != 0);
            req       = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            checks++;
            if ({red, green, blue, grant, busy} !== exp_out()) begin
                failures++;
                $display("FAIL random_model c=%0d: got %b expected %b", c, {red, green, blue, grant, busy}, exp_out());
            end
            tick();
        end
    endtask

    initial begin
        resetb    = 1'b0;
        startgame = 1'b0;
        req       = 4'b0000;
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_rearm();
        test_startgame_drop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
